game_countdown_timer: RTL
=========================

// Module: game_countdown_timer
// PURPOSE
// Level-selectable countdown timer for game control. Divides the system clock into a 1 Hz tick.
// Counts a per-level duration down to zero, with start/pause/resume and bonus-time add.
// Drives an M:SS BCD readout for the VGA overlay and raises a timeout event for the game FSM.
// PARAMETERS
// CLK_HZ    25_000_000  system clock frequency; prescaler terminal count = CLK_HZ-1
// T_BEGIN   60          beginner duration, seconds (level 2'b00 and 2'b01)
// T_MED     45          medium duration, seconds (level 2'b10)
// T_ADV     30          advanced duration, seconds (level 2'b11)
// BONUS_S   5           seconds added per bonus pulse
// MAX_S     599         saturation ceiling for sec_left (9:59)
// SEC_W     10          width of sec_left; must satisfy 2**SEC_W > MAX_S
// PORTS
// clk        in   1      system clock
// reset      in   1      synchronous, active-high reset
// level      in   2      difficulty select, sampled only when a start is accepted
// start      in   1      1-cycle pulse: load the duration for `level` and run
// pause      in   1      1-cycle pulse: toggle RUN<->PAUSE
// bonus      in   1      1-cycle pulse: add BONUS_S seconds (RUN or PAUSE only)
// sec_left   out  SEC_W  remaining seconds (binary)
// min_bcd    out  4      minutes digit of sec_left
// sec_tens   out  4      seconds tens digit (0-5)
// sec_ones   out  4      seconds ones digit (0-9)
// running    out  1      high while state==RUN
// expired    out  1      high while state==EXPIRED
// timeout_p  out  1      single-cycle pulse on entry to EXPIRED
// BEHAVIOUR
// - Reset dominates all inputs. State<=IDLE, prescaler<=0, sec_left<=0; all outputs 0, BCD digits 0.
// - States: IDLE, RUN, PAUSE, EXPIRED.
// - start (any state) -> RUN. sec_left<=duration(level), prescaler<=0.
//   Level 2'b00 or 2'b01 selects T_BEGIN.
// - pause: RUN->PAUSE and PAUSE->RUN. Ignored in IDLE and EXPIRED.
//   If start and pause arrive in the same cycle, start wins.
// - Prescaler advances only in RUN. It holds its value in PAUSE, so a resume continues the partial second.
//   tick = (state==RUN && prescaler==CLK_HZ-1); prescaler wraps to 0 on tick.
// - On tick: sec_left<=sec_left-1. If the result is 0: state<=EXPIRED and timeout_p=1 for exactly that next cycle.
// - bonus in RUN/PAUSE: sec_left<=min(sec_left+BONUS_S, MAX_S). Ignored in IDLE and EXPIRED.
// - bonus together with tick: sec_left<=min(sec_left-1+BONUS_S, MAX_S).
//   If sec_left==1, the result is BONUS_S and there is no expiry.
// - EXPIRED holds sec_left==0 until start or reset; timeout_p never re-fires while in EXPIRED.
// - A duration of 0 from a level makes start go straight to EXPIRED with timeout_p.
// - BCD digits are registered, one cycle after sec_left; the display lags by one clock.
//   min_bcd = sec_left/60, remainder split into tens/ones. Valid for sec_left <= MAX_S.
// - All arithmetic is unsigned SEC_W. Decrement only occurs when sec_left>=1, so there is no underflow.
// STRUCTURE
// - game_timer_pkg: level_t (BEGIN0, BEGIN1, MED, ADV), state_t enum, and a duration lookup function.
// - Sub-module sec_to_bcd: registered binary-seconds to M/S-tens/S-ones converter
//   (subtract-60 / subtract-10 loop, unrolled up to MAX_S).
// - Top level holds the FSM, prescaler, sec_left register and the saturating adder.
// TESTING (bench uses CLK_HZ=4, default durations)
// 1. reset, level=2'b11, start -> running=1, sec_left=30; after 4 clks sec_left=29, after 120 clks
//    sec_left=0, expired=1, timeout_p high for exactly 1 cycle.
// 2. level=2'b01, start -> sec_left=60, min_bcd=1, sec_tens=0, sec_ones=0 one cycle later.
//    After one tick: 0,5,9.
// 3. Run 2 clks into a second, pause for 50 clks, resume -> next decrement after 2 more clks;
//    sec_left is unchanged throughout the pause.
// 4. level=2'b10, sec_left=1 with bonus coincident with tick -> sec_left=5, no timeout_p, running=1.
//    Bonus at sec_left=598 -> 599 (saturated).
// 5. Assert reset mid-RUN with sec_left=17 -> next cycle all outputs 0 and state IDLE.
//    Pause pulse while IDLE -> no change.
// 6. start asserted during EXPIRED with level=2'b00 -> sec_left=60, running=1, expired=0, no timeout_p.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game countdown timer.
// Level and state encodings plus the per-level duration lookup.
package game_timer_pkg;

  typedef enum logic [1:0] {
    BEGIN0 = 2'b00,
    BEGIN1 = 2'b01,
    MED    = 2'b10,
    ADV    = 2'b11
  } level_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  localparam int DUR_W = 16;

  // Both beginner encodings share the long duration.
  function automatic logic [DUR_W-1:0] duration(
    input level_t           lvl,
    input logic [DUR_W-1:0] t_beg,
    input logic [DUR_W-1:0] t_med,
    input logic [DUR_W-1:0] t_adv
  );
    logic [DUR_W-1:0] d;
    unique case (1'b1)
      lvl == MED: d = t_med;
      lvl == ADV: d = t_adv;
      default:    d = t_beg;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_countdown_timer_bcd.sv
// Registered binary-seconds to M:SS BCD converter.
// Subtract loops are unrolled up to the saturation ceiling.
module sec_to_bcd #(
  parameter int SEC_W = 10,
  parameter int MAX_S = 599
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEC_W-1:0] sec,
  output logic [3:0]       min_bcd,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones
);

  localparam logic [SEC_W-1:0] SIXTY = SEC_W'(60);
  localparam logic [SEC_W-1:0] TEN   = SEC_W'(10);

  logic [SEC_W-1:0] r;
  logic [3:0]       m;
  logic [3:0]       t;

  // Peel off whole minutes, then whole tens of seconds.
  always_comb begin
    r = sec;
    m = '0;
    t = '0;
    for (int i = 0; i < MAX_S / 60; i++) begin
      if (r >= SIXTY) begin
        r = r - SIXTY;
        m = m + 4'd1;
      end
    end
    for (int j = 0; j < 5; j++) begin
      if (r >= TEN) begin
        r = r - TEN;
        t = t + 4'd1;
      end
    end
  end

  // Digits are registered so the display lags sec by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_bcd  <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else begin
      min_bcd  <= m;
      sec_tens <= t;
      sec_ones <= r[3:0];
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Level-selectable game countdown timer with 1 Hz prescaler,
// pause/resume, saturating bonus add and a timeout pulse.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int T_BEGIN = 60,
  parameter int T_MED   = 45,
  parameter int T_ADV   = 30,
  parameter int BONUS_S = 5,
  parameter int MAX_S   = 599,
  parameter int SEC_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       level,
  input  logic             start,
  input  logic             pause,
  input  logic             bonus,
  output logic [SEC_W-1:0] sec_left,
  output logic [3:0]       min_bcd,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones,
  output logic             running,
  output logic             expired,
  output logic             timeout_p
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRE_TC = PW'(CLK_HZ - 1);
  localparam logic [SEC_W:0] BON    = (SEC_W+1)'(BONUS_S);
  localparam logic [SEC_W:0] CEIL   = (SEC_W+1)'(MAX_S);

  state_t           state_q;
  state_t           state_d;
  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic [SEC_W-1:0] sec_q;
  logic [SEC_W-1:0] sec_d;
  logic [SEC_W-1:0] dur;
  logic [SEC_W:0]   sum;
  logic             tick;
  logic             to_q;
  logic             to_d;

  assign tick = (state_q == RUN) && (pre_q == PRE_TC);
  assign dur  = SEC_W'(duration(level_t'(level),
                                DUR_W'(T_BEGIN),
                                DUR_W'(T_MED),
                                DUR_W'(T_ADV)));

  // Next seconds value: optional tick decrement plus
  // optional bonus, clamped to the ceiling. One spare bit
  // keeps the sum from wrapping before the clamp.
  always_comb begin
    sum = {1'b0, sec_q} - {{SEC_W{1'b0}}, tick};
    if (bonus) sum = sum + BON;
    if (sum > CEIL) sum = CEIL;
  end

  // Next state, prescaler, seconds and timeout pulse.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    to_d    = 1'b0;
    if (start) begin
      sec_d = dur;
      pre_d = '0;
      if (dur == '0) begin
        state_d = EXPIRED;
        to_d    = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          sec_d = sum[SEC_W-1:0];
          if (tick && sum == '0) begin
            state_d = EXPIRED;
            to_d    = 1'b1;
          end else if (pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          sec_d = sum[SEC_W-1:0];
          if (pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      sec_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      to_q    <= to_d;
    end
  end

  assign sec_left  = sec_q;
  assign running   = (state_q == RUN);
  assign expired   = (state_q == EXPIRED);
  assign timeout_p = to_q;

  sec_to_bcd #(
    .SEC_W (SEC_W),
    .MAX_S (MAX_S)
  ) u_bcd (
    .clk      (clk),
    .reset    (reset),
    .sec      (sec_q),
    .min_bcd  (min_bcd),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );

endmodule
